// File: rtl/bch_dec_codec_if.sv
// Request/response bundle between the DEC BCH codec and its client.
// The client drives the *_i signals and the codec drives the *_o signals.
interface bch_dec_codec_if #(
    parameter int P_D_WIDTH = 21,
    parameter int P_E_WIDTH = 10
);
    logic                 enc_vld_i;
    logic [P_D_WIDTH-1:0] enc_d_i;
    logic                 enc_vld_o;
    logic [P_E_WIDTH-1:0] enc_p_o;
    logic                 dcd_vld_i;
    logic [P_D_WIDTH-1:0] d_i;
    logic [P_E_WIDTH-1:0] ecc_i;
    logic                 dcd_vld_o;
    logic [P_D_WIDTH-1:0] msk_o;
    logic                 err_det_o;
    logic                 err_unc_o;

    modport master (
        output enc_vld_i, enc_d_i, dcd_vld_i, d_i, ecc_i,
        input  enc_vld_o, enc_p_o, dcd_vld_o, msk_o, err_det_o, err_unc_o
    );

    modport slave (
        input  enc_vld_i, enc_d_i, dcd_vld_i, d_i, ecc_i,
        output enc_vld_o, enc_p_o, dcd_vld_o, msk_o, err_det_o, err_unc_o
    );
endinterface

// File: rtl/bch_dec_codec.sv
// Double-error-correcting binary BCH codec: check-bit generation on the write path
// and syndrome / Chien-search correction on the read path, both with one-cycle latency.
module bch_dec_codec #(
    parameter int P_D_WIDTH = 21
) (
    input  logic           clk,
    input  logic           rst,
    bch_dec_codec_if.slave bus
);

    function automatic int calc_m(input int d);
        int m;
        m = 0;
        for (int k = 16; k >= 2; k--) begin
            if (d + 2 * k <= (1 << k) - 1) begin
                m = k;
            end
        end
        return m;
    endfunction

    function automatic int prim_poly(input int m);
        int p;
        case (m)
            32'd4:   p = 32'h0000_0013;
            32'd5:   p = 32'h0000_0025;
            32'd6:   p = 32'h0000_0043;
            32'd7:   p = 32'h0000_0089;
            32'd8:   p = 32'h0000_011D;
            32'd9:   p = 32'h0000_0211;
            default: p = 32'h0000_0025;
        endcase
        return p;
    endfunction

    localparam int M         = calc_m(P_D_WIDTH);
    localparam int P_E_WIDTH = 2 * M;
    localparam int N         = P_D_WIDTH + P_E_WIDTH;
    localparam int Q         = (1 << M) - 1;
    localparam int CW        = $clog2(N + 1);
    localparam int PRIM      = prim_poly(M);

    localparam logic [M-1:0]    PRIM_LO   = PRIM[M-1:0];
    localparam logic [M-1:0]    GF_ZERO   = {M{1'b0}};
    localparam logic [M-1:0]    GF_ONE    = {{(M-1){1'b0}}, 1'b1};
    localparam logic [M-1:0]    GF_ALPHA  = {{(M-2){1'b0}}, 2'b10};
    localparam int              TWO_INT   = 2;
    localparam logic [CW-1:0]   TWO_ROOTS = TWO_INT[CW-1:0];

    // GF(2^M) product, shift-and-add with reduction by the primitive polynomial
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] sh;
        acc = GF_ZERO;
        sh  = a;
        for (int k = 0; k < M; k++) begin
            acc = acc ^ (sh & {M{b[k]}});
            sh  = {sh[M-2:0], 1'b0} ^ (PRIM_LO & {M{sh[M-1]}});
        end
        return acc;
    endfunction

    function automatic logic [M-1:0] gf_pow(input int e);
        logic [M-1:0] r;
        r = GF_ONE;
        for (int k = 0; k < e; k++) begin
            r = gf_mul(r, GF_ALPHA);
        end
        return r;
    endfunction

    // Table of alpha^(step*i) for every codeword position i
    function automatic logic [N*M-1:0] pow_tbl(input int step);
        logic [N*M-1:0] t;
        logic [M-1:0]   base;
        logic [M-1:0]   r;
        base = gf_pow(step % Q);
        r    = GF_ONE;
        for (int i = 0; i < N; i++) begin
            t[i*M +: M] = r;
            r = gf_mul(r, base);
        end
        return t;
    endfunction

    // g(x) = m1(x)*m3(x), built as the product of (x + beta) over both conjugacy classes
    function automatic logic [P_E_WIDTH:0] calc_g();
        logic [M-1:0]       c [0:P_E_WIDTH];
        logic [M-1:0]       beta;
        logic [P_E_WIDTH:0] g;
        int                 e;
        for (int t = 0; t <= P_E_WIDTH; t++) begin
            c[t] = GF_ZERO;
        end
        c[0] = GF_ONE;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < M; k++) begin
                e    = (((r == 0) ? 1 : 3) << k) % Q;
                beta = gf_pow(e);
                for (int t = P_E_WIDTH; t >= 1; t--) begin
                    c[t] = c[t-1] ^ gf_mul(c[t], beta);
                end
                c[0] = gf_mul(c[0], beta);
            end
        end
        for (int t = 0; t <= P_E_WIDTH; t++) begin
            g[t] = c[t][0];
        end
        return g;
    endfunction

    // Column j holds x^(2M+j) mod g(x): the check bits contributed by data bit j
    function automatic logic [P_D_WIDTH*P_E_WIDTH-1:0] calc_cols(input logic [P_E_WIDTH:0] g);
        logic [P_E_WIDTH-1:0]           rem;
        logic [P_D_WIDTH*P_E_WIDTH-1:0] t;
        rem = g[P_E_WIDTH-1:0];
        for (int j = 0; j < P_D_WIDTH; j++) begin
            t[j*P_E_WIDTH +: P_E_WIDTH] = rem;
            rem = {rem[P_E_WIDTH-2:0], 1'b0} ^ (g[P_E_WIDTH-1:0] & {P_E_WIDTH{rem[P_E_WIDTH-1]}});
        end
        return t;
    endfunction

    localparam logic [P_E_WIDTH:0]             GEN      = calc_g();
    localparam logic [P_D_WIDTH*P_E_WIDTH-1:0] ENC_COLS = calc_cols(GEN);
    localparam logic [N*M-1:0]                 POW1     = pow_tbl(1);
    localparam logic [N*M-1:0]                 POW2     = pow_tbl(2);
    localparam logic [N*M-1:0]                 POW3     = pow_tbl(3);

    logic [P_E_WIDTH-1:0] enc_p_s;
    logic [N-1:0]         rcv_s;
    logic [M-1:0]         s1_s;
    logic [M-1:0]         s3_s;
    logic [M-1:0]         s1_sq_s;
    logic [M-1:0]         c0_s;
    logic [N-1:0]         hit_s;
    logic [N-1:0]         root_s;
    logic [CW-1:0]        root_cnt_s;
    logic [P_D_WIDTH-1:0] msk_s;
    logic                 det_s;
    logic                 unc_s;

    logic                 enc_vld_r;
    logic [P_E_WIDTH-1:0] enc_p_r;
    logic                 dcd_vld_r;
    logic [P_D_WIDTH-1:0] msk_r;
    logic                 det_r;
    logic                 unc_r;

    // Check bits: XOR of the columns selected by the set data bits
    always_comb begin
        enc_p_s = {P_E_WIDTH{1'b0}};
        for (int j = 0; j < P_D_WIDTH; j++) begin
            enc_p_s = enc_p_s ^ (ENC_COLS[j*P_E_WIDTH +: P_E_WIDTH] & {P_E_WIDTH{bus.enc_d_i[j]}});
        end
    end

    assign rcv_s = {bus.d_i, bus.ecc_i};

    // Syndromes S1 = r(alpha), S3 = r(alpha^3)
    always_comb begin
        s1_s = GF_ZERO;
        s3_s = GF_ZERO;
        for (int i = 0; i < N; i++) begin
            s1_s = s1_s ^ (POW1[i*M +: M] & {M{rcv_s[i]}});
            s3_s = s3_s ^ (POW3[i*M +: M] & {M{rcv_s[i]}});
        end
    end

    assign s1_sq_s = gf_mul(s1_s, s1_s);
    assign c0_s    = s3_s ^ gf_mul(s1_sq_s, s1_s);

    // Locator scaled by S1 to avoid a divider: S1*X^2 + S1^2*X + (S3 + S1^3)
    always_comb begin
        hit_s      = {N{1'b0}};
        root_s     = {N{1'b0}};
        root_cnt_s = {CW{1'b0}};
        for (int i = 0; i < N; i++) begin
            hit_s[i]   = (s1_s == POW1[i*M +: M]);
            root_s[i]  = ((gf_mul(s1_s, POW2[i*M +: M]) ^ gf_mul(s1_sq_s, POW1[i*M +: M]) ^ c0_s) == GF_ZERO);
            root_cnt_s = root_cnt_s + {{(CW-1){1'b0}}, root_s[i]};
        end
    end

    // Classify the syndrome pair and build the data correction mask
    always_comb begin
        msk_s = {P_D_WIDTH{1'b0}};
        det_s = 1'b0;
        unc_s = 1'b0;
        if (s1_s == GF_ZERO) begin
            det_s = (s3_s != GF_ZERO);
            unc_s = (s3_s != GF_ZERO);
        end else if (c0_s == GF_ZERO) begin
            det_s = 1'b1;
            if (|hit_s) begin
                msk_s = hit_s[N-1:P_E_WIDTH];
            end else begin
                unc_s = 1'b1;
            end
        end else begin
            det_s = 1'b1;
            if (root_cnt_s == TWO_ROOTS) begin
                msk_s = root_s[N-1:P_E_WIDTH];
            end else begin
                unc_s = 1'b1;
            end
        end
    end

    // Encode result register; the check bits only reload on an accepted request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_vld_r <= 1'b0;
            enc_p_r   <= {P_E_WIDTH{1'b0}};
        end else begin
            enc_vld_r <= bus.enc_vld_i;
            if (bus.enc_vld_i) begin
                enc_p_r <= enc_p_s;
            end
        end
    end

    // Decode result registers; the mask and flags only reload on an accepted request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcd_vld_r <= 1'b0;
            msk_r     <= {P_D_WIDTH{1'b0}};
            det_r     <= 1'b0;
            unc_r     <= 1'b0;
        end else begin
            dcd_vld_r <= bus.dcd_vld_i;
            if (bus.dcd_vld_i) begin
                msk_r <= msk_s;
                det_r <= det_s;
                unc_r <= unc_s;
            end
        end
    end

    assign bus.enc_vld_o = enc_vld_r;
    assign bus.enc_p_o   = enc_p_r;
    assign bus.dcd_vld_o = dcd_vld_r;
    assign bus.msk_o     = msk_r;
    assign bus.err_det_o = det_r;
    assign bus.err_unc_o = unc_r;

endmodule

// File: tb/tb_bch_dec_codec.sv
// Scoreboard bench for bch_dec_codec (D=21): a driver queues expected results
// from a polynomial-division reference model, a monitor pops them on each valid.
module tb_bch_dec_codec;
    localparam int D = 21;
    localparam int E = 10;
    localparam int N = 31;
    localparam logic [5:0] M1_POLY = 6'b100101;
    localparam logic [5:0] M3_POLY = 6'b111101;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bch_dec_codec_if #(.P_D_WIDTH(D), .P_E_WIDTH(E)) bus ();
    bch_dec_codec #(.P_D_WIDTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { logic [E-1:0] p; int cyc; } enc_exp_t;
    typedef struct { logic [D-1:0] msk; logic det; logic unc; bit det_only; int cyc; } dcd_exp_t;

    enc_exp_t eq[$];
    dcd_exp_t dq[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference encoder: long division of d(x)*x^10 by g(x) = m1(x)*m3(x)
    function automatic logic [E-1:0] model_enc(input logic [D-1:0] d);
        logic [10:0] g;
        logic [N-1:0] w;
        g = 11'd0;
        for (int k = 0; k < 6; k++) if (M3_POLY[k]) g = g ^ ({5'd0, M1_POLY} << k);
        w = {d, {E{1'b0}}};
        for (int b = N - 1; b >= E; b--) if (w[b]) w = w ^ ({20'd0, g} << (b - E));
        return w[E-1:0];
    endfunction

    task automatic drive(input bit ev, input logic [D-1:0] ed, input bit dv, input logic [N-1:0] rw,
                         input logic [D-1:0] emsk, input bit edet, input bit eunc, input bit donly);
        enc_exp_t ee;
        dcd_exp_t de;
        @(posedge clk);
        #1;
        bus.enc_vld_i = ev;
        bus.enc_d_i   = ed;
        bus.dcd_vld_i = dv;
        bus.d_i       = rw[N-1:E];
        bus.ecc_i     = rw[E-1:0];
        if (ev) begin
            ee.p = model_enc(ed); ee.cyc = cyc + 1;
            eq.push_back(ee);
        end
        if (dv) begin
            de.msk = emsk; de.det = edet; de.unc = eunc; de.det_only = donly; de.cyc = cyc + 1;
            dq.push_back(de);
        end
    endtask

    function automatic logic [D-1:0] rnd_data();
        logic [31:0] r;
        r = $urandom();
        return r[D-1:0];
    endfunction

    // Monitor: pops the scoreboard on every valid, checks hold behaviour otherwise
    initial begin
        enc_exp_t ee;
        dcd_exp_t de;
        logic [E-1:0] last_p = '0;
        logic [D-1:0] last_m = '0;
        logic last_d = 1'b0;
        logic last_u = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_p = '0; last_m = '0; last_d = 1'b0; last_u = 1'b0;
            end else begin
                if (bus.enc_vld_o) begin
                    if (eq.size() == 0) begin
                        chk("enc_unexpected_vld", 32'd1, 32'd0);
                    end else begin
                        ee = eq.pop_front();
                        chk("enc_p", 32'(bus.enc_p_o), 32'(ee.p));
                        chk("enc_latency", 32'(cyc), 32'(ee.cyc));
                    end
                end else begin
                    chk("enc_hold", 32'(bus.enc_p_o), 32'(last_p));
                end
                if (bus.dcd_vld_o) begin
                    if (dq.size() == 0) begin
                        chk("dcd_unexpected_vld", 32'd1, 32'd0);
                    end else begin
                        de = dq.pop_front();
                        chk("dcd_det", 32'(bus.err_det_o), 32'(de.det));
                        chk("dcd_latency", 32'(cyc), 32'(de.cyc));
                        if (!de.det_only) begin
                            chk("dcd_msk", 32'(bus.msk_o), 32'(de.msk));
                            chk("dcd_unc", 32'(bus.err_unc_o), 32'(de.unc));
                        end
                    end
                end else begin
                    chk("dcd_hold", {bus.err_det_o, bus.err_unc_o, 9'd0, bus.msk_o},
                        {last_d, last_u, 9'd0, last_m});
                end
                last_p = bus.enc_p_o; last_m = bus.msk_o;
                last_d = bus.err_det_o; last_u = bus.err_unc_o;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [D-1:0] d;
        logic [D-1:0] base;
        logic [N-1:0] cw;
        logic [N-1:0] err;
        int p1, p2, p3;

        rst = 1'b1;
        bus.enc_vld_i = 1'b0; bus.enc_d_i = '0;
        bus.dcd_vld_i = 1'b0; bus.d_i = '0; bus.ecc_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enc_vld", 32'(bus.enc_vld_o), 32'd0);
        chk("rst_dcd_vld", 32'(bus.dcd_vld_o), 32'd0);
        chk("rst_enc_p", 32'(bus.enc_p_o), 32'd0);
        chk("rst_msk", 32'(bus.msk_o), 32'd0);
        chk("rst_det", 32'(bus.err_det_o), 32'd0);
        chk("rst_unc", 32'(bus.err_unc_o), 32'd0);
        rst = 1'b0;

        base = 21'h1CADC6;
        cw   = {base, model_enc(base)};
        drive(1'b1, base, 1'b1, cw, 21'h000000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, cw ^ (31'd1 << (E + 4)), 21'h000010, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, cw ^ (31'd1 << (E + 20)) ^ 31'd1, 21'h100000, 1'b1, 1'b0, 1'b0);

        // Every single and double error location pair over the whole codeword
        for (int l1 = 0; l1 < N; l1++) begin
            for (int l2 = 0; l2 < N; l2++) begin
                err = '0; err[l1] = 1'b1; err[l2] = 1'b1;
                drive(1'b1, rnd_data(), 1'b1, cw ^ err, err[N-1:E], 1'b1, 1'b0, 1'b0);
            end
        end

        // Back-to-back alternating clean / double-error words with random encodes
        for (int i = 0; i < 200; i++) begin
            d  = rnd_data();
            cw = {d, model_enc(d)};
            err = '0;
            if (i % 2 == 1) begin
                p1 = $urandom_range(N - 1, 0);
                p2 = (p1 + $urandom_range(N - 1, 1)) % N;
                err[p1] = 1'b1; err[p2] = 1'b1;
            end
            drive(($urandom_range(3, 0) != 0), rnd_data(), 1'b1, cw ^ err, err[N-1:E],
                  (i % 2 == 1), 1'b0, 1'b0);
            if (i % 37 == 36) drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        end

        // Three errors: only detection is defined
        for (int i = 0; i < 24; i++) begin
            d  = rnd_data();
            cw = {d, model_enc(d)};
            p1 = $urandom_range(N - 1, 0);
            p2 = (p1 + $urandom_range(N - 1, 1)) % N;
            do p3 = $urandom_range(N - 1, 0); while (p3 == p1 || p3 == p2);
            err = '0; err[p1] = 1'b1; err[p2] = 1'b1; err[p3] = 1'b1;
            drive(1'b1, d, 1'b1, cw ^ err, '0, 1'b1, 1'b0, 1'b1);
        end
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        // Reset while a double-error decode and an encode are in flight
        d  = rnd_data();
        cw = {d, model_enc(d)} ^ (31'd1 << 3) ^ (31'd1 << 25);
        @(posedge clk);
        #1;
        bus.enc_vld_i = 1'b1; bus.enc_d_i = 21'h1FFFFF;
        bus.dcd_vld_i = 1'b1; bus.d_i = cw[N-1:E]; bus.ecc_i = cw[E-1:0];
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_enc_vld", 32'(bus.enc_vld_o), 32'd0);
        chk("arst_dcd_vld", 32'(bus.dcd_vld_o), 32'd0);
        chk("arst_enc_p", 32'(bus.enc_p_o), 32'd0);
        chk("arst_msk", 32'(bus.msk_o), 32'd0);
        chk("arst_det", 32'(bus.err_det_o), 32'd0);
        chk("arst_unc", 32'(bus.err_unc_o), 32'd0);
        @(posedge clk);
        #1;
        chk("arst_dcd_vld_next", 32'(bus.dcd_vld_o), 32'd0);
        chk("arst_msk_next", 32'(bus.msk_o), 32'd0);
        rst = 1'b0;
        bus.enc_vld_i = 1'b0; bus.dcd_vld_i = 1'b0;
        eq.delete();
        dq.delete();

        // First request after reset release is accepted on the next edge
        cw = {base, model_enc(base)} ^ (31'd1 << (E + 7));
        drive(1'b1, base, 1'b1, cw, 21'h000080, 1'b1, 1'b0, 1'b0);
        repeat (3) drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        chk("enc_queue_drained", 32'(eq.size()), 32'd0);
        chk("dcd_queue_drained", 32'(dq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
